// File: rtl/fft_addr_gen.sv
// FFT frame address generator: emits offset+k (linear) or offset+bit-reversed k per N-word frame.
// Bit-reversed ordering is compiled in only when FFT_ADDR_BITREV_EN is defined.
module fft_addr_gen #(
  parameter int ADDR_W = 32,
  parameter int LOG2_N = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              start,
  input  logic [ADDR_W-1:0] offset,
  input  logic [ADDR_W-1:0] filesize,
  input  logic              bitrev,
  input  logic              ready,
  output logic [ADDR_W-1:0] addr,
  output logic              addr_valid,
  output logic              frame_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] k;
  logic [ADDR_W-1:0] offset_p0;
  logic [ADDR_W-1:0] filesize_p0;
  logic              br_start;
  logic              br_run;
  logic [ADDR_W-1:0] k_next;
  logic [ADDR_W-1:0] addr_next;
  logic              last_next;
  logic              last_word;

  function automatic logic [ADDR_W-1:0] bit_reverse_low(input logic [ADDR_W-1:0] v);
    logic [ADDR_W-1:0] r;
    r = v;
    for (int i = 0; i < LOG2_N; i++) begin
      r[i] = v[LOG2_N-1-i];
    end
    return r;
  endfunction

  // Only words inside complete N-word frames are reordered; the trailing partial frame stays linear.
  function automatic logic [ADDR_W-1:0] calc_addr(input logic [ADDR_W-1:0] k_in,
                                                  input logic [ADDR_W-1:0] off,
                                                  input logic [ADDR_W-1:0] fs,
                                                  input logic              br);
    logic [ADDR_W-1:0] idx;
    idx = k_in;
    if (br && ((k_in >> LOG2_N) < (fs >> LOG2_N))) begin
      idx = bit_reverse_low(k_in);
    end
    return off + idx;
  endfunction

  function automatic logic is_last(input logic [ADDR_W-1:0] k_in,
                                   input logic [ADDR_W-1:0] fs);
    return (&k_in[LOG2_N-1:0]) || (k_in == fs - ADDR_W'(1));
  endfunction

`ifdef FFT_ADDR_BITREV_EN
  logic bitrev_p0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitrev_p0 <= 1'b0;
    end else if (state == IDLE && start && enable) begin
      bitrev_p0 <= bitrev;
    end
  end

  assign br_start = bitrev;
  assign br_run   = bitrev_p0;
`else
  logic unused_bitrev;
  assign unused_bitrev = bitrev;
  assign br_start      = 1'b0;
  assign br_run        = 1'b0;
`endif

  assign k_next    = k + ADDR_W'(1);
  assign addr_next = calc_addr(k_next, offset_p0, filesize_p0, br_run);
  assign last_next = is_last(k_next, filesize_p0);
  assign last_word = (k == filesize_p0 - ADDR_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      k           <= '0;
      offset_p0   <= '0;
      filesize_p0 <= '0;
      addr        <= '0;
      addr_valid  <= 1'b0;
      frame_last  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start && enable) begin
            offset_p0   <= offset;
            filesize_p0 <= filesize;
            k           <= '0;
            busy        <= 1'b1;
            if (filesize != '0) begin
              state      <= RUN;
              addr       <= calc_addr('0, offset, filesize, br_start);
              addr_valid <= 1'b1;
              frame_last <= is_last('0, filesize);
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (!enable) begin
            // Abort: drop the transfer silently, no completion pulse.
            state      <= IDLE;
            k          <= '0;
            addr_valid <= 1'b0;
            frame_last <= 1'b0;
            busy       <= 1'b0;
          end else if (ready) begin
            if (last_word) begin
              state      <= DONE;
              addr_valid <= 1'b0;
              frame_last <= 1'b0;
              done       <= 1'b1;
            end else begin
              k          <= k_next;
              addr       <= addr_next;
              frame_last <= last_next;
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state      <= IDLE;
          addr_valid <= 1'b0;
          frame_last <= 1'b0;
          busy       <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fft_addr_gen.sv
// Directed bench for fft_addr_gen: a queue-based frame-order model checked every valid cycle,
// plus literal address expectations for the hand-worked cases.
module tb_fft_addr_gen;

  localparam int  AW    = 32;
  localparam int  LOG2N = 8;
  localparam longint NW = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          start = 1'b0;
  logic [AW-1:0] offset = '0;
  logic [AW-1:0] filesize = '0;
  logic          bitrev = 1'b0;
  logic          ready = 1'b0;
  logic [AW-1:0] addr;
  logic          addr_valid;
  logic          frame_last;
  logic          busy;
  logic          done;

  fft_addr_gen #(.ADDR_W(AW), .LOG2_N(LOG2N)) dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .offset(offset),
    .filesize(filesize), .bitrev(bitrev), .ready(ready), .addr(addr),
    .addr_valid(addr_valid), .frame_last(frame_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct { logic [AW-1:0] a; logic l; } item_t;
  item_t exp_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int stall_cnt = 0;
  int done_cnt = 0;
  int exp_done_cyc = -1;
  logic [AW-1:0] got_addr [10000];
  logic          got_last [10000];

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Expected sequence from frame arithmetic: full frames permuted, tail linear.
  function automatic void build_model(input logic [AW-1:0] off, input logic [AW-1:0] fs, input logic br);
    longint full, fsl, fr, j, r, t;
    item_t it;
    logic br_eff;
`ifdef FFT_ADDR_BITREV_EN
    br_eff = br;
`else
    br_eff = 1'b0;
`endif
    exp_q.delete();
    fsl  = longint'(fs);
    full = (fsl / NW) * NW;
    for (longint k = 0; k < fsl; k++) begin
      if (br_eff && k < full) begin
        fr = k / NW;
        j  = k % NW;
        r  = 0;
        t  = j;
        for (int b = 0; b < LOG2N; b++) begin
          r = r * 2 + t % 2;
          t = t / 2;
        end
        it.a = AW'(longint'(off) + fr * NW + r);
      end else begin
        it.a = AW'(longint'(off) + k);
      end
      it.l = (k % NW == NW - 1) || (k == fsl - 1);
      exp_q.push_back(it);
    end
  endfunction

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (addr_valid) begin
        if (done) check("valid_during_done", 1, 0);
        if (exp_q.size() == 0) begin
          check("unexpected_valid", addr_valid, 0);
        end else begin
          check("addr", addr, exp_q[0].a);
          check("frame_last", frame_last, exp_q[0].l);
          if (ready && enable) begin
            if (acc_cnt < 10000) begin
              got_addr[acc_cnt] = addr;
              got_last[acc_cnt] = frame_last;
            end
            void'(exp_q.pop_front());
            acc_cnt++;
            if (exp_q.size() == 0) exp_done_cyc = cyc + 1;
          end else if (!ready) begin
            stall_cnt++;
          end
        end
      end
      if (done || cyc == exp_done_cyc) begin
        check("done_pulse", done, 1);
        check("done_cycle", cyc, exp_done_cyc);
        if (done) done_cnt++;
        exp_done_cyc = -1;
      end
    end
  end

  task automatic xfer(input bit sync, input logic [AW-1:0] off, input logic [AW-1:0] fs,
                      input logic br, input int stall_k, input int stall_len,
                      input int restart_k, input int abort_k, input int reset_k);
    int n, budget, used, dbefore;
    bit restarted;
    build_model(off, fs, br);
    acc_cnt   = 0;
    stall_cnt = 0;
    used      = 0;
    restarted = 0;
    dbefore   = done_cnt;
    if (sync) begin
      @(posedge clk);
      #1;
    end
    offset = off; filesize = fs; bitrev = br; enable = 1; ready = 1; start = 1;
    if (fs == 0) exp_done_cyc = cyc + 2;
    @(posedge clk);
    #1;
    start = 0;
    check("busy_after_start", busy, 1);
    budget = int'(fs) + stall_len + 50;
    n = 0;
    while (done_cnt == dbefore && n < budget) begin
      if (acc_cnt == abort_k) begin
        enable = 0;
        @(posedge clk);
        #1;
        check("abort_valid", addr_valid, 0);
        check("abort_busy", busy, 0);
        exp_q.delete();
        enable = 1;
        repeat (5) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt, dbefore);
        return;
      end
      if (acc_cnt == reset_k) begin
        #2 rst = 1;
        #1;
        check("rst_addr", addr, 0);
        check("rst_valid", addr_valid, 0);
        check("rst_last", frame_last, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        exp_q.delete();
        exp_done_cyc = -1;
        rst = 0;
        return;
      end
      ready = !(acc_cnt == stall_k && used < stall_len);
      if (!ready) used++;
      if (acc_cnt == restart_k && !restarted) begin
        start = 1; offset = off + 32'h1000; filesize = fs - 2; bitrev = ~br; restarted = 1;
      end else begin
        start = 0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    if (done_cnt == dbefore) check("done_timeout", 0, 1);
    check("words_left", exp_q.size(), 0);
    check("done_count", done_cnt - dbefore, 1);
    @(negedge clk);
    #1;
    check("busy_idle", busy, 0);
    check("done_low", done, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    #1;
    check("reset_addr", addr, 0);
    check("reset_valid", addr_valid, 0);
    check("reset_last", frame_last, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    rst = 0;

    // Linear 10000-word file, started on the first edge after reset release.
    xfer(0, 32'd0, 32'd10000, 1'b0, -1, 0, -1, -1, -1);
    check("a_addr_0", got_addr[0], 0);
    check("a_addr_9999", got_addr[9999], 9999);
    check("a_last_255", got_last[255], 1);
    check("a_last_256", got_last[256], 0);
    check("a_last_511", got_last[511], 1);
    check("a_last_9999", got_last[9999], 1);

    // Two full bit-reversed frames.
    xfer(1, 32'd100524, 32'd512, 1'b1, -1, 0, -1, -1, -1);
    check("b_addr_0", got_addr[0], 100524);
`ifdef FFT_ADDR_BITREV_EN
    check("b_addr_1", got_addr[1], 100652);
    check("b_addr_2", got_addr[2], 100588);
    check("b_addr_3", got_addr[3], 100716);
`else
    check("b_addr_1", got_addr[1], 100525);
    check("b_addr_2", got_addr[2], 100526);
    check("b_addr_3", got_addr[3], 100527);
`endif
    check("b_addr_256", got_addr[256], 100780);

    // One full frame plus a linear 44-word tail.
    xfer(1, 32'd1000, 32'd300, 1'b1, -1, 0, -1, -1, -1);
`ifdef FFT_ADDR_BITREV_EN
    check("c_addr_1", got_addr[1], 1128);
`else
    check("c_addr_1", got_addr[1], 1001);
`endif
    check("c_addr_256", got_addr[256], 1256);
    check("c_addr_299", got_addr[299], 1299);
    check("c_last_299", got_last[299], 1);

    // Stall at k=5 for three cycles; a start while busy must be ignored.
    xfer(1, 32'd50, 32'd20, 1'b0, 5, 3, 10, -1, -1);
    check("d_stall_cycles", stall_cnt, 3);
    check("d_addr_5", got_addr[5], 55);
    check("d_addr_6", got_addr[6], 56);
    check("d_addr_19", got_addr[19], 69);

    // Abort at k=100 of 1000, then a fresh start restarts from offset.
    xfer(1, 32'd7, 32'd1000, 1'b0, -1, 0, -1, 100, -1);
    xfer(1, 32'd7, 32'd3, 1'b0, -1, 0, -1, -1, -1);
    check("e_restart_addr_0", got_addr[0], 7);
    check("e_restart_last_2", got_last[2], 1);

    // Empty file.
    xfer(1, 32'd123, 32'd0, 1'b0, -1, 0, -1, -1, -1);

    // Address wrap past 2^32.
    xfer(1, 32'hFFFF_FFFE, 32'd4, 1'b1, -1, 0, -1, -1, -1);
    check("g_addr_0", got_addr[0], 32'hFFFF_FFFE);
    check("g_addr_1", got_addr[1], 32'hFFFF_FFFF);
    check("g_addr_2", got_addr[2], 0);
    check("g_addr_3", got_addr[3], 1);

    // Asynchronous reset mid-transfer, then immediate restart.
    xfer(1, 32'd500, 32'd40, 1'b0, -1, 0, -1, -1, 12);
    xfer(0, 32'd900, 32'd5, 1'b0, -1, 0, -1, -1, -1);
    check("h_addr_0", got_addr[0], 900);
    check("h_addr_4", got_addr[4], 904);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_addr_gen.md
FFT_ADDR_GEN -- requirements
Module: fft_addr_gen

Interface
REQ-001 Parameter ADDR_W, default 32: width of offset, filesize and addr.
REQ-002 Parameter LOG2_N, default 8: log2 of FFT frame length N (N=256); legal range 2..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 enable  input  1  level run-enable; low aborts any transfer in progress.
REQ-006 start  input  1  one-cycle request; sampled only in IDLE with enable high.
REQ-007 offset  input  ADDR_W  base address; latched on accepted start.
REQ-008 filesize  input  ADDR_W  number of words to address; latched on accepted start.
REQ-009 bitrev  input  1  1 = bit-reversed order within each N-word frame; latched on accepted start.
REQ-010 ready  input  1  downstream accepts addr when ready and addr_valid are both high.
REQ-011 addr  output  ADDR_W  current generated address (registered).
REQ-012 addr_valid  output  1  addr is valid.
REQ-013 frame_last  output  1  qualifies addr as the last word of a frame or of the file.
REQ-014 busy  output  1  high in RUN and DONE.
REQ-015 done  output  1  one-cycle pulse at completion.

Function
REQ-016 FSM states: IDLE, RUN, DONE; IDLE->RUN on start&enable&filesize!=0; IDLE->DONE on start&enable&filesize==0; RUN->DONE on acceptance of word filesize-1; DONE->IDLE unconditionally after one cycle.
REQ-017 Internal counter k (ADDR_W bits) = 0 on start, +1 on each accepted word; no increment on stall.
REQ-018 First addr_valid in the cycle after accepted start (latency 1); valid stays high every RUN cycle.
REQ-019 While addr_valid & !ready, addr, addr_valid and frame_last hold stable.
REQ-020 Linear order: addr = offset + k, modulo 2^ADDR_W (wraps silently).
REQ-021 Bit-reversed order: addr = offset + {k[ADDR_W-1:LOG2_N], reverse(k[LOG2_N-1:0])}, modulo 2^ADDR_W.
REQ-022 Trailing partial frame (k >= filesize rounded down to a multiple of N) is always emitted in linear order.
REQ-023 frame_last = 1 when k[LOG2_N-1:0]==N-1 or k==filesize-1.
REQ-024 done pulses high for exactly the DONE-state cycle; addr_valid is low in DONE.
REQ-025 start while busy is ignored; latched parameters do not change until the next accepted start.
REQ-026 enable low in RUN: next cycle state=IDLE, addr_valid=0, no done pulse, k discarded.
REQ-027 enable low in DONE: done still pulses; return to IDLE.

Reset
REQ-028 rst high forces state=IDLE, k=0, addr=0, addr_valid=0, frame_last=0, busy=0, done=0 immediately, independent of clk.
REQ-029 rst mid-transfer discards the transfer; no done pulse is produced for it.
REQ-030 First start is accepted on the first rising edge after rst deasserts.

Configuration
REQ-031 Macro FFT_ADDR_BITREV_EN defined: bit-reversal logic of REQ-021/022 is compiled in and bitrev behaves as specified.
REQ-032 FFT_ADDR_BITREV_EN undefined: bitrev input is ignored and all transfers use linear order; all other behaviour is unchanged.

Verification
REQ-033 offset=0, filesize=10000, bitrev=0, ready=1 -> addr 0..9999 on consecutive cycles, frame_last on 255,511,..., and 9999; done pulses once, one cycle after addr 9999.
REQ-034 offset=100524, filesize=512, bitrev=1 (macro on), LOG2_N=8 -> first addrs 100524,100652,100588,100716; word 256 = 100780; done after 512 accepts.
REQ-035 filesize=300, bitrev=1 -> words 256..299 linear (offset+256..offset+299); same stimulus with macro off -> all 300 linear.
REQ-036 ready low for 3 cycles at k=5 -> addr=offset+5 held stable 3 cycles, no skipped or repeated address.
REQ-037 enable dropped at k=100 of 1000 -> addr_valid low next cycle, no done; start again -> restarts at offset+0.
REQ-038 filesize=0 -> done one cycle after start, addr_valid never high; offset=0xFFFFFFFE, filesize=4 -> addrs FFFFFFFE, FFFFFFFF, 0, 1.
